irq_axil_forwarder: RTL

- Parametrised multi-target interrupt forwarder: watches NumTarget-style per-target irq levels from an interrupt controller and mirrors each level change into a remote register as an AXI4-Lite master write.
- Generalises the single-address irq-to-AXIL path in three ways: configurable target count, per-target address stride, and selectable forwarding mode.
- Adds round-robin arbitration, change coalescing, bounded retry on error responses, and status outputs.
- Sits beside rv_plic inside the PLIC wrapper; its master port drives the host-side interrupt-pending registers.

---
 rtl/irq_fwd_pkg.sv | 5 +
 rtl/irq_fwd_rr_arb.sv | 28 ++
 rtl/irq_axil_forwarder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/irq_fwd_pkg.sv
// Shared types for the irq-to-AXI4-Lite forwarder.
package irq_fwd_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  localparam logic [1:0] OKAY = 2'b00;
endpackage

// File: rtl/irq_fwd_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr wins; one-hot grant plus index.
module irq_fwd_rr_arb #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/irq_axil_forwarder.sv
// Mirrors per-target irq level changes into remote registers as single AXI4-Lite writes,
// one outstanding at a time, with round-robin selection and bounded retry.
module irq_axil_forwarder import irq_fwd_pkg::*; #(
  parameter int              num_targets_p     = 2,
  parameter int              axil_data_width_p = 32,
  parameter int              axil_addr_width_p = 32,
  parameter longint unsigned base_addr_p       = 64'h30_b000,
  parameter int unsigned     stride_p          = 4,
  parameter bit              set_only_p        = 1'b0,
  parameter int              max_retries_p     = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [num_targets_p-1:0]       irq_i,
  input  logic [num_targets_p-1:0]       en_i,
  output logic [axil_addr_width_p-1:0]   m_axil_awaddr_o,
  output logic [2:0]                     m_axil_awprot_o,
  output logic                           m_axil_awvalid_o,
  input  logic                           m_axil_awready_i,
  output logic [axil_data_width_p-1:0]   m_axil_wdata_o,
  output logic [axil_data_width_p/8-1:0] m_axil_wstrb_o,
  output logic                           m_axil_wvalid_o,
  input  logic                           m_axil_wready_i,
  input  logic [1:0]                     m_axil_bresp_i,
  input  logic                           m_axil_bvalid_i,
  output logic                           m_axil_bready_o,
  output logic                           busy_o,
  output logic                           drop_o,
  output logic [7:0]                     drop_cnt_o
);
  localparam int N  = num_targets_p;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = axil_addr_width_p;
  localparam int RW = $clog2(max_retries_p + 2);

  state_e          state, state_nxt;
  logic [N-1:0]    sent_r, dirty, gnt;
  logic [IW-1:0]   ptr_r, idx_r, sel;
  logic            val_r, any, aw_pend, w_pend, drop_r;
  logic [RW-1:0]   retry_r;
  logic [7:0]      drop_cnt_r;
  logic            issue_done, resp_done, b_ok, can_retry, drop_ev;

  // In set-only mode a target is only ever forwarded while its line is high.
  assign dirty = en_i & (irq_i ^ sent_r) & (set_only_p ? irq_i : {N{1'b1}});

  irq_fwd_rr_arb #(.N(N), .IW(IW)) u_arb (
    .req(dirty), .ptr(ptr_r), .gnt(gnt), .idx(sel), .any(any)
  );

  assign issue_done = (~aw_pend | m_axil_awready_i) & (~w_pend | m_axil_wready_i);
  assign resp_done  = (state == RESP) & m_axil_bvalid_i;
  assign b_ok       = (m_axil_bresp_i == OKAY);
  assign can_retry  = (retry_r < RW'(max_retries_p));
  assign drop_ev    = resp_done & ~b_ok & ~can_retry;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any) state_nxt = ISSUE;
      ISSUE:   if (issue_done) state_nxt = RESP;
      RESP:    if (m_axil_bvalid_i) state_nxt = (!b_ok && can_retry) ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_axil_awvalid_o = (state == ISSUE) & aw_pend;
    m_axil_wvalid_o  = (state == ISSUE) & w_pend;
    m_axil_bready_o  = (state == RESP);
    busy_o           = (state != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sent_r     <= '0;
      ptr_r      <= '0;
      idx_r      <= '0;
      val_r      <= 1'b0;
      retry_r    <= '0;
      aw_pend    <= 1'b0;
      w_pend     <= 1'b0;
      drop_r     <= 1'b0;
      drop_cnt_r <= '0;
    end else begin
      // Falling lines are acknowledged locally; a completing response below still wins.
      if (set_only_p) sent_r <= sent_r & irq_i;
      drop_r <= drop_ev;
      if (state == IDLE && any) begin
        idx_r   <= sel;
        val_r   <= |(gnt & irq_i);
        retry_r <= '0;
        aw_pend <= 1'b1;
        w_pend  <= 1'b1;
      end
      if (state == ISSUE) begin
        if (m_axil_awready_i) aw_pend <= 1'b0;
        if (m_axil_wready_i)  w_pend  <= 1'b0;
      end
      if (resp_done) begin
        if (!b_ok && can_retry) begin
          retry_r <= retry_r + 1'b1;
          aw_pend <= 1'b1;
          w_pend  <= 1'b1;
        end else begin
          sent_r[idx_r] <= val_r;
          ptr_r         <= (idx_r == IW'(N - 1)) ? '0 : idx_r + 1'b1;
          if (drop_ev && drop_cnt_r != 8'hff) drop_cnt_r <= drop_cnt_r + 1'b1;
        end
      end
    end
  end

  assign m_axil_awaddr_o = AW'(base_addr_p) + AW'(idx_r) * AW'(stride_p);
  assign m_axil_awprot_o = 3'b000;
  assign m_axil_wdata_o  = axil_data_width_p'(val_r);
  assign m_axil_wstrb_o  = '1;
  assign drop_o          = drop_r;
  assign drop_cnt_o      = drop_cnt_r;
endmodule
